// File: rtl/plic_pkg.sv
// rtl/plic_pkg.sv - shared PLIC claim/complete constants, FSM states and helpers
package plic_pkg;

    typedef logic [2:0] plic_state_t;

    localparam plic_state_t ST_IDLE       = 3'd0;
    localparam plic_state_t ST_CLAIM_REQ  = 3'd1;
    localparam plic_state_t ST_CLAIM_RESP = 3'd2;
    localparam plic_state_t ST_PRESENT    = 3'd3;
    localparam plic_state_t ST_SERVICE    = 3'd4;
    localparam plic_state_t ST_CMPL_REQ   = 3'd5;
    localparam plic_state_t ST_CMPL_RESP  = 3'd6;

    // Offset of context 0 claim/complete register from the PLIC base
    localparam logic [31:0] CLAIM_OFFSET = 32'h0020_0004;

    // Context encoding: machine-mode and supervisor-mode hart contexts
    localparam logic CTX_M = 1'b0;
    localparam logic CTX_S = 1'b1;

    localparam logic [3:0] WSTRB_READ = 4'h0;
    localparam logic [3:0] WSTRB_WORD = 4'hF;

    // A claim returning 0 or an ID that does not fit in 5 bits is not serviceable
    function automatic logic claim_is_spurious(input logic [31:0] value);
        return (value == 32'd0) || (value[31:5] != 27'd0);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Count up on each event, holding at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (inc_i && !(&count_q)) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/irq_claim_agent.sv
// rtl/irq_claim_agent.sv - PLIC claim/present/complete agent; IRQ_CLAIM_STATS_EN adds claim counters
module irq_claim_agent
    import plic_pkg::*;
#(
    parameter logic [31:0] PLIC_BASE  = 32'h0C00_0000,
    parameter logic [31:0] CTX_STRIDE = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mei_i,
    input  logic        sei_i,
    output logic        req_valid_o,
    output logic [31:0] req_addr_o,
    output logic [31:0] req_value_o,
    output logic [3:0]  req_wstrb_o,
    input  logic        req_ready_i,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_value_i,
    output logic        irq_valid_o,
    output logic [4:0]  irq_id_o,
    output logic        irq_ctx_o,
    input  logic        irq_ready_i,
    input  logic        done_i
`ifdef IRQ_CLAIM_STATS_EN
    ,
    output logic [15:0] claims_o,
    output logic [15:0] spurious_o
`endif
);

    plic_state_t state_q, state_d;
    logic        ctx_q, ctx_d;
    logic [4:0]  id_q, id_d;
    logic [31:0] claim_addr;

    // Both claim read and complete write target the latched context's register
    assign claim_addr = PLIC_BASE + CLAIM_OFFSET + (ctx_q ? CTX_STRIDE : 32'd0);

    // Sequencing: claim read, present to core, wait for handler, complete write
    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                // Lines are only looked at here; M context wins a tie
                if (mei_i || sei_i) begin
                    ctx_d   = mei_i ? CTX_M : CTX_S;
                    state_d = ST_CLAIM_REQ;
                end
            end
            ST_CLAIM_REQ: begin
                if (req_ready_i) begin
                    state_d = ST_CLAIM_RESP;
                end
            end
            ST_CLAIM_RESP: begin
                if (resp_valid_i) begin
                    if (claim_is_spurious(resp_value_i)) begin
                        state_d = ST_IDLE;
                    end else begin
                        id_d    = resp_value_i[4:0];
                        state_d = ST_PRESENT;
                    end
                end
            end
            ST_PRESENT: begin
                if (irq_ready_i) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (done_i) begin
                    state_d = ST_CMPL_REQ;
                end
            end
            ST_CMPL_REQ: begin
                if (req_ready_i) begin
                    state_d = ST_CMPL_RESP;
                end
            end
            ST_CMPL_RESP: begin
                if (resp_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, context and claimed ID registers; reset drops any transaction in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ctx_q   <= CTX_M;
            id_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            id_q    <= id_d;
        end
    end

    // Request outputs come straight from state, so they are stable until accepted and zero when idle
    always_comb begin
        req_valid_o = 1'b0;
        req_addr_o  = 32'd0;
        req_value_o = 32'd0;
        req_wstrb_o = WSTRB_READ;
        if (state_q == ST_CLAIM_REQ) begin
            req_valid_o = 1'b1;
            req_addr_o  = claim_addr;
        end else if (state_q == ST_CMPL_REQ) begin
            req_valid_o = 1'b1;
            req_addr_o  = claim_addr;
            req_value_o = {27'd0, id_q};
            req_wstrb_o = WSTRB_WORD;
        end
    end

    assign irq_valid_o = (state_q == ST_PRESENT);
    assign irq_id_o    = irq_valid_o ? id_q : 5'd0;
    assign irq_ctx_o   = irq_valid_o & ctx_q;

`ifdef IRQ_CLAIM_STATS_EN
    logic claim_resp;
    logic claim_bad;

    assign claim_resp = (state_q == ST_CLAIM_RESP) && resp_valid_i;
    assign claim_bad  = claim_is_spurious(resp_value_i);

    sat_counter #(.W(16)) u_claims (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (claim_resp && !claim_bad),
        .count_o (claims_o)
    );

    sat_counter #(.W(16)) u_spurious (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (claim_resp && claim_bad),
        .count_o (spurious_o)
    );
`endif

endmodule

// File: tb/tb_irq_claim_agent.sv
// tb/tb_irq_claim_agent.sv - randomized self-checking bench for irq_claim_agent
module tb_irq_claim_agent;

    logic        clk = 1'b0;
    logic        rst_i, mei_i, sei_i;
    logic        req_valid_o;
    logic [31:0] req_addr_o, req_value_o;
    logic [3:0]  req_wstrb_o;
    logic        req_ready_i, resp_valid_i;
    logic [31:0] resp_value_i;
    logic        irq_valid_o;
    logic [4:0]  irq_id_o;
    logic        irq_ctx_o;
    logic        irq_ready_i, done_i;
`ifdef IRQ_CLAIM_STATS_EN
    logic [15:0] claims_o, spurious_o;
    int          exp_claims = 0;
    int          exp_spur   = 0;
`endif

    always #5 clk = ~clk;

    irq_claim_agent dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .mei_i        (mei_i),
        .sei_i        (sei_i),
        .req_valid_o  (req_valid_o),
        .req_addr_o   (req_addr_o),
        .req_value_o  (req_value_o),
        .req_wstrb_o  (req_wstrb_o),
        .req_ready_i  (req_ready_i),
        .resp_valid_i (resp_valid_i),
        .resp_value_i (resp_value_i),
        .irq_valid_o  (irq_valid_o),
        .irq_id_o     (irq_id_o),
        .irq_ctx_o    (irq_ctx_o),
        .irq_ready_i  (irq_ready_i),
        .done_i       (done_i)
`ifdef IRQ_CLAIM_STATS_EN
        ,
        .claims_o     (claims_o),
        .spurious_o   (spurious_o)
`endif
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] value;
        logic [3:0]  wstrb;
    } xfer_t;

    typedef struct packed {
        logic [4:0] id;
        logic       ctx;
    } pres_t;

    xfer_t obs_x[$];
    xfer_t exp_x[$];
    pres_t obs_p[$];
    pres_t exp_p[$];
    int    pass_cnt  = 0;
    int    total_cnt = 0;
    logic  irq_prev  = 1'b0;

    // Monitor: every accepted request, and every new presentation to the core
    always @(negedge clk) begin
        if (req_valid_o && req_ready_i) obs_x.push_back({req_addr_o, req_value_o, req_wstrb_o});
        if (irq_valid_o && !irq_prev) obs_p.push_back({irq_id_o, irq_ctx_o});
        irq_prev = irq_valid_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    // Reference: one interrupt event as seen on the bus and at the core
    function automatic void model_seq(input bit m_line, input logic [31:0] val);
        logic        ctx;
        logic [31:0] addr;
        ctx  = m_line ? 1'b0 : 1'b1;
        addr = 32'h0C20_0004 + (ctx ? 32'h0000_1000 : 32'h0);
        exp_x.push_back({addr, 32'h0, 4'h0});
        if (val == 32'd0 || val > 32'd31) begin
`ifdef IRQ_CLAIM_STATS_EN
            if (exp_spur < 65535) exp_spur++;
`endif
        end else begin
            exp_p.push_back({val[4:0], ctx});
            exp_x.push_back({addr, val, 4'hF});
`ifdef IRQ_CLAIM_STATS_EN
            if (exp_claims < 65535) exp_claims++;
`endif
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        obs_x.delete(); exp_x.delete(); obs_p.delete(); exp_p.delete();
    endtask

    task automatic bus_xfer(input int stall, output bit to, output bit unstable, output int held);
        logic [31:0] a, v;
        logic [3:0]  s;
        int          n;
        n = 0; to = 0; unstable = 0; held = 0;
        while (!req_valid_o && n < 40) begin
            cyc(1);
            n++;
        end
        if (!req_valid_o) begin
            to = 1;
            return;
        end
        a = req_addr_o; v = req_value_o; s = req_wstrb_o;
        for (int i = 0; i <= stall; i++) begin
            if (!req_valid_o || req_addr_o !== a || req_value_o !== v || req_wstrb_o !== s) unstable = 1;
            else held++;
            req_ready_i = (i == stall);
            cyc(1);
        end
        req_ready_i = 1'b0;
    endtask

    task automatic respond(input int lat, input logic [31:0] val);
        cyc(lat);
        resp_valid_i = 1'b1;
        resp_value_i = val;
        cyc(1);
        resp_valid_i = 1'b0;
        resp_value_i = $urandom;
    endtask

    task automatic take_irq(input int delay, output bit to);
        int n;
        n = 0; to = 0;
        while (!irq_valid_o && n < 40) begin
            cyc(1);
            n++;
        end
        if (!irq_valid_o) begin
            to = 1;
            return;
        end
        cyc(delay);
        irq_ready_i = 1'b1;
        cyc(1);
        irq_ready_i = 1'b0;
    endtask

    task automatic done_pulse(input int delay);
        cyc(delay);
        done_i = 1'b1;
        cyc(1);
        done_i = 1'b0;
    endtask

    // Plays bus target and core for one claim sequence; err flags timeouts or unstable requests
    task automatic run_seq(input logic [31:0] val, input int stall, input bit drop_m, input bit drop_s,
                           output bit err);
        bit t, u;
        int h, st;
        err = 0;
        bus_xfer(stall, t, u, h);
        err |= t | u | (h != stall + 1);
        if (drop_m) mei_i = 1'b0;
        if (drop_s) sei_i = 1'b0;
        respond($urandom_range(0, 3), val);
        if (val != 32'd0 && val <= 32'd31) begin
            take_irq($urandom_range(0, 2), t);
            err |= t;
            done_pulse($urandom_range(0, 3));
            st = $urandom_range(0, 2);
            bus_xfer(st, t, u, h);
            err |= t | u | (h != st + 1);
            respond($urandom_range(0, 3), $urandom);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cyc(2);
        total_cnt++; if (req_valid_o !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", req_valid_o); else pass_cnt++;
        total_cnt++; if (req_addr_o !== 32'd0) $display("FAIL reset_req_addr: got %h want 0", req_addr_o); else pass_cnt++;
        total_cnt++; if (req_value_o !== 32'd0) $display("FAIL reset_req_value: got %h want 0", req_value_o); else pass_cnt++;
        total_cnt++; if (req_wstrb_o !== 4'd0) $display("FAIL reset_req_wstrb: got %h want 0", req_wstrb_o); else pass_cnt++;
        total_cnt++; if ({irq_valid_o, irq_id_o, irq_ctx_o} !== 7'd0)
            $display("FAIL reset_irq: got %h want 0", {irq_valid_o, irq_id_o, irq_ctx_o}); else pass_cnt++;
`ifdef IRQ_CLAIM_STATS_EN
        total_cnt++; if ({claims_o, spurious_o} !== 32'd0)
            $display("FAIL reset_stats: got %h want 0", {claims_o, spurious_o}); else pass_cnt++;
`endif
        rst_i = 1'b0;
        cyc(1);
    endtask

    // Shared ending of the log-based tests: compare what was seen against the model
    task automatic test_logs_compare(input string name);
        cyc(3);
        total_cnt++; if (obs_x.size() !== exp_x.size())
            $display("FAIL %s_xfer_count: got %0d want %0d", name, obs_x.size(), exp_x.size()); else pass_cnt++;
        for (int i = 0; i < exp_x.size() && i < obs_x.size(); i++) begin
            total_cnt++; if (obs_x[i] !== exp_x[i])
                $display("FAIL %s_xfer%0d: got %h want %h", name, i, obs_x[i], exp_x[i]); else pass_cnt++;
        end
        total_cnt++; if (obs_p.size() !== exp_p.size())
            $display("FAIL %s_irq_count: got %0d want %0d", name, obs_p.size(), exp_p.size()); else pass_cnt++;
        for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
            total_cnt++; if (obs_p[i] !== exp_p[i])
                $display("FAIL %s_irq%0d: got %h want %h", name, i, obs_p[i], exp_p[i]); else pass_cnt++;
        end
`ifdef IRQ_CLAIM_STATS_EN
        total_cnt++; if (claims_o !== 16'(exp_claims))
            $display("FAIL %s_claims: got %0d want %0d", name, claims_o, exp_claims); else pass_cnt++;
        total_cnt++; if (spurious_o !== 16'(exp_spur))
            $display("FAIL %s_spurious: got %0d want %0d", name, spurious_o, exp_spur); else pass_cnt++;
`endif
    endtask

    task automatic test_m_claim();
        bit err;
        clear_logs();
        mei_i = 1'b1;
        model_seq(1'b1, 32'h0000_0007);
        run_seq(32'h0000_0007, 0, 1'b1, 1'b1, err);
        total_cnt++; if (err !== 1'b0) $display("FAIL m_claim_handshake: got %b want 0", err); else pass_cnt++;
        test_logs_compare("m_claim");
    endtask

    task automatic test_s_claim();
        bit err;
        clear_logs();
        sei_i = 1'b1;
        model_seq(1'b0, 32'h0000_0003);
        run_seq(32'h0000_0003, 0, 1'b1, 1'b1, err);
        total_cnt++; if (err !== 1'b0) $display("FAIL s_claim_handshake: got %b want 0", err); else pass_cnt++;
        test_logs_compare("s_claim");
    endtask

    task automatic test_priority();
        bit e1, e2;
        clear_logs();
        mei_i = 1'b1;
        sei_i = 1'b1;
        model_seq(1'b1, 32'd12);
        model_seq(1'b0, 32'd21);
        run_seq(32'd12, 1, 1'b1, 1'b0, e1);
        run_seq(32'd21, 0, 1'b1, 1'b1, e2);
        total_cnt++; if ({e1, e2} !== 2'b00) $display("FAIL priority_handshake: got %b want 00", {e1, e2}); else pass_cnt++;
        test_logs_compare("priority");
    endtask

    task automatic test_spurious();
        logic [31:0] vals[3];
        bit          err, any_err;
        bit          m;
        clear_logs();
        vals[0] = 32'h0000_0000;
        vals[1] = 32'h0000_0040;
        vals[2] = {$urandom_range(1, 27'h7FF_FFFF), 5'($urandom)};
        any_err = 0;
        for (int i = 0; i < 3; i++) begin
            m = 1'($urandom);
            mei_i = m;
            sei_i = !m;
            model_seq(m, vals[i]);
            run_seq(vals[i], $urandom_range(0, 2), 1'b1, 1'b1, err);
            any_err |= err;
        end
        total_cnt++; if (any_err !== 1'b0) $display("FAIL spurious_handshake: got %b want 0", any_err); else pass_cnt++;
        test_logs_compare("spurious");
    endtask

    task automatic test_stall();
        bit t, u;
        int h;
        clear_logs();
        mei_i = 1'b1;
        model_seq(1'b1, 32'd0);
        bus_xfer(3, t, u, h);
        mei_i = 1'b0;
        total_cnt++; if (t !== 1'b0) $display("FAIL stall_timeout: got %b want 0", t); else pass_cnt++;
        total_cnt++; if (u !== 1'b0) $display("FAIL stall_stable: got %b want 0", u); else pass_cnt++;
        total_cnt++; if (h !== 4) $display("FAIL stall_held_cycles: got %0d want 4", h); else pass_cnt++;
        total_cnt++; if (req_valid_o !== 1'b0) $display("FAIL stall_valid_after: got %b want 0", req_valid_o); else pass_cnt++;
        respond(2, 32'd0);
        test_logs_compare("stall");
    endtask

    task automatic test_random();
        bit          err, any_err;
        int          pat;
        logic [31:0] val;
        clear_logs();
        any_err = 0;
        for (int i = 0; i < 20; i++) begin
            pat = $urandom_range(1, 3);
            if ($urandom_range(0, 4) == 0) val = ($urandom_range(0, 1) == 0) ? 32'd0 : ($urandom | 32'h0000_0020);
            else val = $urandom_range(1, 31);
            mei_i = pat[0];
            sei_i = pat[1];
            model_seq(pat[0], val);
            run_seq(val, $urandom_range(0, 3), 1'b1, 1'b1, err);
            any_err |= err;
        end
        total_cnt++; if (any_err !== 1'b0) $display("FAIL random_handshake: got %b want 0", any_err); else pass_cnt++;
        test_logs_compare("random");
    endtask

    task automatic test_reset_mid();
        bit t, u, t2;
        int h;
        clear_logs();
        mei_i = 1'b1;
        bus_xfer(0, t, u, h);
        mei_i = 1'b0;
        respond(1, 32'd9);
        take_irq(0, t2);
        cyc(2);
        total_cnt++; if ({t, u, t2} !== 3'b000) $display("FAIL rstmid_setup: got %b want 000", {t, u, t2}); else pass_cnt++;
        rst_i = 1'b1;
        cyc(1);
        total_cnt++; if ({req_valid_o, req_addr_o, req_value_o, req_wstrb_o} !== 69'd0)
            $display("FAIL rstmid_req_outputs: got %h want 0", {req_valid_o, req_addr_o, req_value_o, req_wstrb_o});
        else pass_cnt++;
        total_cnt++; if ({irq_valid_o, irq_id_o, irq_ctx_o} !== 7'd0)
            $display("FAIL rstmid_irq_outputs: got %h want 0", {irq_valid_o, irq_id_o, irq_ctx_o}); else pass_cnt++;
        rst_i = 1'b0;
        respond(0, 32'd5);
        done_pulse(0);
        cyc(8);
        total_cnt++; if (obs_x.size() !== 1) $display("FAIL rstmid_no_complete: got %0d xfers want 1", obs_x.size()); else pass_cnt++;
        total_cnt++; if (obs_p.size() !== 1) $display("FAIL rstmid_presentations: got %0d want 1", obs_p.size()); else pass_cnt++;
        total_cnt++; if ({req_valid_o, irq_valid_o} !== 2'b00)
            $display("FAIL rstmid_idle_after: got %b want 00", {req_valid_o, irq_valid_o}); else pass_cnt++;
`ifdef IRQ_CLAIM_STATS_EN
        exp_claims = 0;
        exp_spur   = 0;
        total_cnt++; if ({claims_o, spurious_o} !== 32'd0)
            $display("FAIL rstmid_stats: got %h want 0", {claims_o, spurious_o}); else pass_cnt++;
`endif
    endtask

    initial begin
        rst_i = 1'b1; mei_i = 1'b0; sei_i = 1'b0;
        req_ready_i = 1'b0; resp_valid_i = 1'b0; resp_value_i = 32'd0;
        irq_ready_i = 1'b0; done_i = 1'b0;
        test_reset();
        test_m_claim();
        test_s_claim();
        test_priority();
        test_spurious();
        test_stall();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
